// File: rtl/diaosi_types_pkg.sv
// Shared types for the memory responder: controller state encoding and the
// handshake encoding reported by the RAM model on ramstate.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    DONE = 2'd3
  } memstate_t;

  typedef enum logic [1:0] {
    RS_FREE   = 2'd0,
    RS_BUSY   = 2'd1,
    RS_ACCESS = 2'd2,
    RS_ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_responder.sv
// Arbitrates instruction fetches and data loads/stores onto a single RAM port.
// Data requests win over fetches; every access is bounded by WAIT_LIMIT cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; accept data first, then fetch
// DACC  | data load/store driven onto the RAM, waiting for ACCESS
// IACC  | instruction fetch driven onto the RAM, waiting for ACCESS
// DONE  | one-cycle completion beat carrying ihit/dhit
module mem_responder
  import diaosi_types_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  memstate_t   state_q, state_d;
  logic [CW-1:0] wait_q, wait_d, wait_inc;
  // live: the requester is still asking; cleared if it lets go while waiting
  logic        live_q, live_d;
  logic        wr_q, wr_d;
  logic        req_now;
  logic        ren_d, wen_d, ihit_d, dhit_d, terr_d;
  logic [31:0] addr_d, store_d, iload_d, dload_d;

  assign wait_inc = wait_q + CW'(1);

  // Next-state and next-output decode; every output is taken from a register.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    live_d  = live_q;
    wr_d    = wr_q;
    ren_d   = ramREN;
    wen_d   = ramWEN;
    addr_d  = ramaddr;
    store_d = ramstore;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    iload_d = iload;
    dload_d = dload;
    terr_d  = timeout_err;
    req_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (dREN | dWEN) begin
          state_d = DACC;
          wait_d  = '0;
          live_d  = 1'b1;
          wr_d    = dWEN;
          ren_d   = dREN;
          wen_d   = dWEN;
          addr_d  = daddr;
          store_d = dstore;
        end else if (iREN & ~halt) begin
          state_d = IACC;
          wait_d  = '0;
          live_d  = 1'b1;
          wr_d    = 1'b0;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          addr_d  = iaddr;
          store_d = '0;
        end
      end
      DACC, IACC: begin
        if (state_q == IACC) req_now = iREN;
        else if (wr_q)       req_now = dWEN;
        else                 req_now = dREN;
        if (ramstate == RS_ACCESS) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == IACC) begin
            iload_d = ramload;
            ihit_d  = live_q;
          end else begin
            if (!wr_q) dload_d = ramload;
            dhit_d = live_q;
          end
        end else begin
          // FREE, BUSY and ERROR all mean the RAM has not answered yet
          wait_d = wait_inc;
          live_d = live_q & req_now;
          if (wait_inc == CW'(WAIT_LIMIT)) begin
            state_d = IDLE;
            terr_d  = 1'b1;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      live_q      <= 1'b0;
      wr_q        <= 1'b0;
      ramREN      <= 1'b0;
      ramWEN      <= 1'b0;
      ramaddr     <= '0;
      ramstore    <= '0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      iload       <= '0;
      dload       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      live_q      <= live_d;
      wr_q        <= wr_d;
      ramREN      <= ren_d;
      ramWEN      <= wen_d;
      ramaddr     <= addr_d;
      ramstore    <= store_d;
      ihit        <= ihit_d;
      dhit        <= dhit_d;
      iload       <= iload_d;
      dload       <= dload_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction-level model predicts every
// output each cycle, and each scenario also pins a few hand-computed values.
module tb_mem_responder;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errs = 0;
  int checks = 0;

  mem_responder #(.WAIT_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .halt(halt),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {K_LD, K_ST, K_IF} kind_t;
  bit          m_busy, m_beat, m_want;
  kind_t       m_kind;
  int          m_waits;
  logic        e_ihit, e_dhit, e_ren, e_wen, e_terr;
  logic [31:0] e_iload, e_dload, e_addr, e_store;

  task automatic model_reset();
    m_busy = 0; m_beat = 0; m_want = 0; m_waits = 0; m_kind = K_LD;
    e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_terr = 0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
  endtask

  function automatic bit still_asking(input kind_t k);
    case (k)
      K_IF:    return bit'(iREN);
      K_LD:    return bit'(dREN);
      default: return bit'(dWEN);
    endcase
  endfunction

  task automatic model_step();
    e_ihit = 0;
    e_dhit = 0;
    if (m_beat) begin
      m_beat = 0;
    end else if (!m_busy) begin
      if (dREN || dWEN) begin
        m_busy = 1; m_want = 1; m_waits = 0;
        m_kind = dWEN ? K_ST : K_LD;
        e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
      end else if (iREN && !halt) begin
        m_busy = 1; m_want = 1; m_waits = 0; m_kind = K_IF;
        e_ren = 1; e_wen = 0; e_addr = iaddr; e_store = '0;
      end
    end else if (ramstate == ACC) begin
      if (m_kind == K_IF) begin
        e_iload = ramload;
        e_ihit = m_want;
      end else begin
        if (m_kind == K_LD) e_dload = ramload;
        e_dhit = m_want;
      end
      e_ren = 0; e_wen = 0; m_busy = 0; m_beat = 1;
    end else begin
      m_waits++;
      if (!still_asking(m_kind)) m_want = 0;
      if (m_waits == LIMIT) begin
        e_terr = 1; e_ren = 0; e_wen = 0; m_busy = 0;
      end
    end
  endtask

  // Advance the model on each rising edge and compare just after it.
  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      if (!nRST) model_reset();
      else model_step();
      #1;
      chk("ihit", 32'(ihit), 32'(e_ihit));
      chk("dhit", 32'(dhit), 32'(e_dhit));
      chk("ramREN", 32'(ramREN), 32'(e_ren));
      chk("ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("timeout_err", 32'(timeout_err), 32'(e_terr));
      chk("iload", iload, e_iload);
      chk("dload", dload, e_dload);
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    nRST = 0; halt = 0; iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    quiet();
    nclk(2);
    chk("rst ramREN", 32'(ramREN), 32'd0);
    chk("rst ramaddr", ramaddr, 32'd0);
    chk("rst terr", 32'(timeout_err), 32'd0);
    nRST = 1;
    nclk(2);

    // load, ACCESS on first wait cycle: dhit two cycles after the request
    dREN = 1; daddr = 32'h40;
    nclk(1);
    chk("ld ramREN", 32'(ramREN), 32'd1);
    chk("ld ramaddr", ramaddr, 32'h40);
    ramstate = ACC; ramload = 32'hDEADBEEF;
    nclk(1);
    chk("ld dhit", 32'(dhit), 32'd1);
    chk("ld dload", dload, 32'hDEADBEEF);
    quiet();
    nclk(1);
    chk("ld dhit pulse", 32'(dhit), 32'd0);
    nclk(2);

    // store and fetch together: store first, then fetch
    iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = BUSY;
    nclk(1);
    chk("st ramWEN", 32'(ramWEN), 32'd1);
    chk("st ramREN", 32'(ramREN), 32'd0);
    chk("st ramaddr", ramaddr, 32'h80);
    chk("st ramstore", ramstore, 32'h1234);
    ramstate = ACC;
    nclk(1);
    chk("st dhit", 32'(dhit), 32'd1);
    chk("st ihit", 32'(ihit), 32'd0);
    dWEN = 0; ramstate = FREE;
    nclk(2);
    chk("if ramREN", 32'(ramREN), 32'd1);
    chk("if ramaddr", ramaddr, 32'h100);
    ramstate = ACC; ramload = 32'hCAFE0001;
    nclk(1);
    chk("if ihit", 32'(ihit), 32'd1);
    chk("if iload", iload, 32'hCAFE0001);
    quiet();
    nclk(2);

    // three BUSY cycles then ACCESS: ram side stable four cycles, one hit
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      if (ramREN && ramaddr == 32'h44) cnt++;
    end
    chk("busy3 stable cycles", 32'(cnt), 32'd4);
    ramstate = ACC; ramload = 32'h0BADF00D;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      if (dhit) cnt++;
      dREN = 0; ramstate = FREE;
    end
    chk("busy3 hit count", 32'(cnt), 32'd1);
    chk("busy3 dload", dload, 32'h0BADF00D);
    nclk(1);

    // request dropped while waiting: RAM completes, hit suppressed
    dREN = 1; daddr = 32'h60; ramstate = BUSY;
    nclk(1);
    dREN = 0;
    nclk(1);
    ramstate = ACC; ramload = 32'h77;
    nclk(1);
    chk("drop dhit", 32'(dhit), 32'd0);
    chk("drop dload", dload, 32'h77);
    chk("drop ramREN", 32'(ramREN), 32'd0);
    quiet();
    nclk(2);

    // FREE and ERROR before ACCESS keep the fetch pending
    iREN = 1; iaddr = 32'h40; ramstate = FREE;
    nclk(2);
    ramstate = ERR;
    nclk(1);
    ramstate = ACC; ramload = 32'hAB;
    nclk(1);
    chk("err ihit", 32'(ihit), 32'd1);
    chk("err iload", iload, 32'hAB);
    quiet();
    nclk(2);

    // halt mid-fetch: fetch completes, later fetches blocked, data still served
    iREN = 1; iaddr = 32'h200; ramstate = BUSY;
    nclk(1);
    halt = 1;
    nclk(1);
    ramstate = ACC; ramload = 32'h13;
    nclk(1);
    chk("halt ihit", 32'(ihit), 32'd1);
    ramstate = FREE;
    nclk(3);
    chk("halt blocks fetch", 32'(ramREN), 32'd0);
    dREN = 1; daddr = 32'h300;
    nclk(1);
    chk("halt data ramREN", 32'(ramREN), 32'd1);
    chk("halt data ramaddr", ramaddr, 32'h300);
    ramstate = ACC; ramload = 32'h55;
    nclk(1);
    chk("halt dhit", 32'(dhit), 32'd1);
    chk("halt dload", dload, 32'h55);
    quiet(); halt = 0;
    nclk(2);

    // BUSY forever: timeout after LIMIT wait cycles, no hit, back to idle
    dREN = 1; daddr = 32'h90; ramstate = BUSY;
    nclk(4);
    chk("to not yet", 32'(timeout_err), 32'd0);
    nclk(1);
    chk("to terr", 32'(timeout_err), 32'd1);
    chk("to ramREN", 32'(ramREN), 32'd0);
    chk("to dhit", 32'(dhit), 32'd0);
    dREN = 0;
    nclk(2);
    chk("to idle ramREN", 32'(ramREN), 32'd0);
    chk("to sticky", 32'(timeout_err), 32'd1);

    // reset in the middle of a data access
    dREN = 1; daddr = 32'h500; dstore = 32'h99; ramstate = BUSY;
    nclk(2);
    chk("pre-rst ramREN", 32'(ramREN), 32'd1);
    nRST = 0; dREN = 0;
    #1;
    chk("rst ramREN", 32'(ramREN), 32'd0);
    chk("rst ramaddr", ramaddr, 32'd0);
    chk("rst dload", dload, 32'd0);
    chk("rst iload", iload, 32'd0);
    chk("rst terr", 32'(timeout_err), 32'd0);
    nclk(2);
    nRST = 1; ramstate = ACC;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      if (dhit) cnt++;
    end
    chk("rst no dhit", 32'(cnt), 32'd0);
    quiet();
    nclk(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
